toggle_rx: RTL

Receiving end of a toggle-signalling link. A sender's toggle output flips once per event in another clock domain or from a board switch. This block synchronises that level into the local clk domain and optionally deglitches it. It turns each level change into a one-cycle event pulse plus a held pending flag with ack handshake, overflow detection and an event counter. Sits between toggle sources (remote toggle flops, switch inputs) and the VGA control logic.

---
 rtl/toggle_rx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/toggle_rx.sv
// Purpose : receive a toggle-signalling line, synchronise and optionally deglitch it,
//           and turn each accepted level change into a pulse, a pending flag and a count.
// Latency : i_tgl change -> o_level/o_pulse after SYNC_STAGES+FILTER_CYCLES+1 edges.
// Backpr. : none on the toggle line; an event arriving while still pending sets o_ovf.
//
// Ports:
//   clk       system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_sclr    synchronous clear (pending/ovf/count/filter; o_level re-aligned to the line)
//   i_tgl     asynchronous toggle line from the sender
//   i_ack     consumer acknowledge of the pending event
//   o_pulse   one-cycle strobe per accepted change
//   o_pending event received and not yet acknowledged
//   o_level   accepted (synchronised, filtered) level
//   o_ovf     sticky: an event arrived while one was still pending
//   o_count   accepted-event counter, wraps
module toggle_rx #(
  parameter logic INIT          = 1'b0,
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter int   CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_sclr,
  input  logic                 i_tgl,
  input  logic                 i_ack,
  output logic                 o_pulse,
  output logic                 o_pending,
  output logic                 o_level,
  output logic                 o_ovf,
  output logic [CNT_WIDTH-1:0] o_count
);

  // ---------------------------------------------------------------------------
  // Synchroniser. Only the last stage is used downstream. It is not touched by
  // i_sclr so the line keeps being tracked across a clear.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_q;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_tgl};
  assign s_q    = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q <= {SYNC_STAGES{INIT}};
    end else begin
      sync_q <= sync_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Change qualification.
  // ---------------------------------------------------------------------------
  logic level_q;
  logic level_d;
  logic diff;
  logic accept;

  assign diff = s_q ^ level_q;

  if (FILTER_CYCLES == 0) begin : g_nofilt
    assign accept = diff;
  end else begin : g_filt
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam logic [FW-1:0] F_MAX = FW'(FILTER_CYCLES);

    logic [FW-1:0] fcnt_q;
    logic [FW-1:0] fcnt_d;

    // The counter saturates at F_MAX after F differing cycles; the change is
    // taken on the following edge if the line still differs. A level that
    // differs for F cycles or fewer never reaches that edge and is dropped.
    assign accept = diff && (fcnt_q == F_MAX);

    always_comb begin
      fcnt_d = fcnt_q;
      if (i_sclr || !diff || accept) begin
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event bookkeeping. i_sclr wins over an event due in the same cycle.
  // ---------------------------------------------------------------------------
  logic                 evt;
  logic                 pulse_q;
  logic                 pulse_d;
  logic                 pending_q;
  logic                 pending_d;
  logic                 ovf_q;
  logic                 ovf_d;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  assign evt = accept && !i_sclr;

  always_comb begin
    level_d   = level_q;
    pulse_d   = 1'b0;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    if (i_sclr) begin
      // Re-align to the synchronised line so the clear does not itself look
      // like a change on the next cycle.
      level_d   = s_q;
      pending_d = 1'b0;
      ovf_d     = 1'b0;
      count_d   = '0;
    end else if (evt) begin
      level_d   = s_q;
      pulse_d   = 1'b1;
      count_d   = count_q + CNT_WIDTH'(1);
      // A same-cycle ack consumes the previous event, so no overflow then.
      if (pending_q && !i_ack) begin
        ovf_d = 1'b1;
      end
      pending_d = 1'b1;
    end else if (i_ack) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q   <= INIT;
      pulse_q   <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      level_q   <= level_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  assign o_pulse   = pulse_q;
  assign o_pending = pending_q;
  assign o_level   = level_q;
  assign o_ovf     = ovf_q;
  assign o_count   = count_q;

endmodule
